// File: rtl/sos_responder.sv
// Emergency stop sequencer: brings the car to the nearest reachable floor, parks it
// with the brake on and the door open, and blinks the alarm until maintenance clears it.
module sos_responder #(
    parameter int FLOORS    = 8,
    parameter int FLOOR_W   = 3,
    parameter int BLINK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sos_mode,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic               at_floor,
    input  logic [1:0]         car_dir,
    input  logic               maint_clear,
    output logic [FLOOR_W-1:0] target_floor,
    output logic               target_valid,
    output logic               brake,
    output logic               motor_inhibit,
    output logic               door_open,
    output logic               alarm,
    output logic               sos_ack
);

    typedef enum logic [2:0] {IDLE, SEEK, STOP, HOLD, RELEASE} state_t;

    typedef struct packed {
        logic target_valid;
        logic brake;
        logic motor_inhibit;
        logic door_open;
        logic sos_ack;
    } ctl_t;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam int                 CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_DIV - 1);

    state_t             state, state_nx;
    ctl_t               ctl, ctl_nx;
    logic [FLOOR_W-1:0] floor_sat, seek_floor, target_nx;
    logic [CNT_W-1:0]   blink_cnt, blink_cnt_nx;
    logic               alarm_nx;
    logic               alarm_on_nx;

    // Clamp an out-of-range floor report so the latched target is always servable.
    always_comb begin
        if (32'(current_floor) > 32'(FLOORS - 1)) floor_sat = TOP_FLOOR;
        else                                      floor_sat = current_floor;
    end

    always_comb begin
        case (car_dir)
            2'b01:   seek_floor = (floor_sat == TOP_FLOOR) ? TOP_FLOOR : floor_sat + FLOOR_W'(1);
            2'b10:   seek_floor = (floor_sat == '0) ? '0 : floor_sat - FLOOR_W'(1);
            default: seek_floor = floor_sat;
        endcase
    end

    always_comb begin
        state_nx  = state;
        target_nx = target_floor;
        case (state)
            IDLE: begin
                if (sos_mode) begin
                    target_nx = at_floor ? floor_sat : seek_floor;
                    state_nx  = at_floor ? STOP : SEEK;
                end
            end
            // sos_mode is deliberately not consulted once the sequence has started.
            SEEK:    if (at_floor && current_floor == target_floor) state_nx = STOP;
            STOP:    state_nx = HOLD;
            HOLD:    if (maint_clear && !sos_mode) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        ctl_nx = '0;
        case (state_nx)
            SEEK:    ctl_nx.target_valid = 1'b1;
            STOP:    ctl_nx = '{target_valid: 1'b1, brake: 1'b1, motor_inhibit: 1'b1,
                                door_open: 1'b0, sos_ack: 1'b0};
            HOLD:    ctl_nx = '{target_valid: 1'b1, brake: 1'b1, motor_inhibit: 1'b1,
                                door_open: 1'b1, sos_ack: 1'b0};
            RELEASE: ctl_nx = '{target_valid: 1'b1, brake: 1'b1, motor_inhibit: 1'b1,
                                door_open: 1'b0, sos_ack: 1'b1};
            default: ctl_nx = '0;
        endcase
    end

    assign alarm_on_nx = (state_nx == SEEK) || (state_nx == STOP) || (state_nx == HOLD);

    // Blink phase starts lit on leaving IDLE and then runs freely across SEEK/STOP/HOLD.
    always_comb begin
        blink_cnt_nx = '0;
        alarm_nx     = 1'b0;
        if (alarm_on_nx) begin
            if (state == IDLE) begin
                blink_cnt_nx = '0;
                alarm_nx     = 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt_nx = '0;
                alarm_nx     = ~alarm;
            end else begin
                blink_cnt_nx = blink_cnt + CNT_W'(1);
                alarm_nx     = alarm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ctl          <= '0;
            target_floor <= '0;
            blink_cnt    <= '0;
            alarm        <= 1'b0;
        end else begin
            state        <= state_nx;
            ctl          <= ctl_nx;
            target_floor <= target_nx;
            blink_cnt    <= blink_cnt_nx;
            alarm        <= alarm_nx;
        end
    end

    assign target_valid  = ctl.target_valid;
    assign brake         = ctl.brake;
    assign motor_inhibit = ctl.motor_inhibit;
    assign door_open     = ctl.door_open;
    assign sos_ack       = ctl.sos_ack;

endmodule

// File: tb/tb_sos_responder.sv
// Directed bench for sos_responder: at-floor stop, seek while moving, saturation,
// clear handshake and asynchronous reset, all against hand-computed values.
module tb_sos_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sos_mode;
    logic [2:0] current_floor;
    logic       at_floor;
    logic [1:0] car_dir;
    logic       maint_clear;
    logic [2:0] target_floor;
    logic       target_valid, brake, motor_inhibit, door_open, alarm, sos_ack;

    int n_tests = 0;
    int n_fail  = 0;

    sos_responder #(.FLOORS(8), .FLOOR_W(3), .BLINK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .sos_mode(sos_mode), .current_floor(current_floor),
        .at_floor(at_floor), .car_dir(car_dir), .maint_clear(maint_clear),
        .target_floor(target_floor), .target_valid(target_valid), .brake(brake),
        .motor_inhibit(motor_inhibit), .door_open(door_open), .alarm(alarm), .sos_ack(sos_ack)
    );

    always #5 clk = ~clk;

    // {target_valid, brake, motor_inhibit, door_open, alarm, sos_ack}
    logic [5:0] outs;
    assign outs = {target_valid, brake, motor_inhibit, door_open, alarm, sos_ack};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        sos_mode = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sos_mode = 1'b1; at_floor = 1'b1; current_floor = 3'd3;
        car_dir = 2'b00; maint_clear = 1'b0;

        // Reset held with sos_mode high, then at-floor stop
        repeat (3) tick();
        check("rst_outs", 32'(outs), 32'h0);
        check("rst_tgt", 32'(target_floor), 32'd0);
        rst_n = 1'b1;
        tick();
        check("atf_stop", 32'(outs), 32'b111010);
        check("atf_tgt", 32'(target_floor), 32'd3);
        sos_mode = 1'b0;
        tick();
        check("atf_hold", 32'(outs), 32'b111110);
        for (int k = 3; k <= 8; k++) begin
            tick();
            check($sformatf("blink_c%0d", k), 32'(alarm), (k <= 4) ? 32'd1 : 32'd0);
        end

        // Clear ignored while sos_mode is still high
        sos_mode = 1'b1; maint_clear = 1'b1;
        tick();
        check("clr_blocked", 32'(outs), 32'b111110);
        tick();
        check("clr_blocked2", 32'(outs), 32'b111110);
        sos_mode = 1'b0;
        tick();
        check("release", 32'(outs), 32'b111001);
        maint_clear = 1'b0;
        tick();
        check("idle_after", 32'(outs), 32'h0);
        check("idle_tgt_kept", 32'(target_floor), 32'd3);

        // Moving up between floors
        current_floor = 3'd2; car_dir = 2'b01; at_floor = 1'b0; sos_mode = 1'b1;
        tick();
        check("up_seek", 32'(outs), 32'b100010);
        check("up_tgt", 32'(target_floor), 32'd3);
        sos_mode = 1'b0;
        tick();
        check("up_seek_latched", 32'(outs), 32'b100010);
        at_floor = 1'b1;
        tick();
        check("up_wrong_floor", 32'(outs), 32'b100010);
        current_floor = 3'd3;
        tick();
        check("up_stop", 32'(outs), 32'b111010);
        tick();
        check("up_hold", 32'(outs), 32'b111100);
        maint_clear = 1'b1;
        tick();
        check("up_release", 32'(outs), 32'b111001);
        maint_clear = 1'b0;
        tick();
        check("up_idle", 32'(outs), 32'h0);

        // Up saturation, then asynchronous reset mid-SEEK
        current_floor = 3'd7; car_dir = 2'b01; at_floor = 1'b0; sos_mode = 1'b1;
        tick();
        check("sat_up_tgt", 32'(target_floor), 32'd7);
        check("sat_up_outs", 32'(outs), 32'b100010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(outs), 32'h0);
        check("async_rst_tgt", 32'(target_floor), 32'd0);
        sos_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_ack", 32'(outs), 32'h0);

        // Down by one, down saturation, idle direction (11)
        current_floor = 3'd5; car_dir = 2'b10; sos_mode = 1'b1;
        tick();
        check("down_tgt", 32'(target_floor), 32'd4);
        do_reset();
        current_floor = 3'd0; car_dir = 2'b10; sos_mode = 1'b1;
        tick();
        check("sat_down_tgt", 32'(target_floor), 32'd0);
        check("sat_down_outs", 32'(outs), 32'b100010);
        do_reset();
        current_floor = 3'd5; car_dir = 2'b11; sos_mode = 1'b1;
        tick();
        check("dir11_tgt", 32'(target_floor), 32'd5);
        do_reset();
        tick();
        check("final_idle", 32'(outs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
